tdm_demux4: RTL and testbench



---
 rtl/tdm_pkg.sv | 30 +++
 rtl/tdm_slot_ctr.sv | 26 ++
 rtl/tdm_demux4.sv | 127 ++++++++++++
 tb/tb_tdm_demux4.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and sizes for the 4-slot TDM receive path.
package tdm_pkg;

   localparam int N_SLOTS   = 4;
   localparam int SLOT_W    = 2;
   localparam int ERR_CNT_W = 3;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Returns shadow with bit idx replaced by b; idx outside 0..N_SLOTS-2 leaves it untouched.
   function automatic logic [N_SLOTS-2:0] shadow_put(
      input logic [N_SLOTS-2:0] shadow,
      input logic [SLOT_W-1:0]  idx,
      input logic               b
   );
      logic [N_SLOTS-2:0] res;
      res = shadow;
      case (idx)
         2'd0:    res[0] = b;
         2'd1:    res[1] = b;
         2'd2:    res[2] = b;
         default: res    = shadow;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter: wraps 3->0, can be cleared or realigned to slot 1.
// Updates one cycle after the request; clear wins over load, load over advance.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load1,
   input  logic              adv,
   output logic [SLOT_W-1:0] sel
);

   always_ff @(posedge clk) begin
      if (rst) begin
         sel <= '0;
      end else if (clr) begin
         sel <= '0;
      end else if (load1) begin
         sel <= SLOT_W'(1);
      end else if (adv) begin
         sel <= sel + SLOT_W'(1);
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM receiver: serial bits -> 4-bit word with one-cycle valid pulse; lock/error tracking.
// Word appears the cycle after the slot-3 beat; no backpressure, din_valid=0 cycles stall everything.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int ERR_LIMIT = 2
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               din,
   input  logic               din_valid,
   input  logic               frame,
   output logic [SLOT_W-1:0]  sel,
   output logic [N_SLOTS-1:0] out,
   output logic               out_valid,
   output logic               locked,
   output logic               sync_err
);

   localparam logic [ERR_CNT_W:0] LIMIT = ERR_LIMIT[ERR_CNT_W:0];

   state_t                 state, state_nxt;
   logic [N_SLOTS-2:0]     shadow, shadow_nxt;
   logic [ERR_CNT_W-1:0]   err_cnt, err_nxt, err_sat;
   logic [N_SLOTS-1:0]     out_nxt;
   logic                   out_valid_nxt, sync_err_nxt;
   logic                   ctr_clr, ctr_load1, ctr_adv;
   logic                   limit_hit;

   tdm_slot_ctr u_slot_ctr (
      .clk   (clk),
      .rst   (rst),
      .clr   (ctr_clr),
      .load1 (ctr_load1),
      .adv   (ctr_adv),
      .sel   (sel)
   );

   // Error count after this error, saturating at all-ones.
   assign err_sat   = (err_cnt == '1) ? err_cnt : err_cnt + ERR_CNT_W'(1);
   assign limit_hit = ({1'b0, err_cnt} + (ERR_CNT_W+1)'(1)) >= LIMIT;

   always_comb begin
      state_nxt     = state;
      shadow_nxt    = shadow;
      err_nxt       = err_cnt;
      out_nxt       = out;
      out_valid_nxt = 1'b0;
      sync_err_nxt  = 1'b0;
      ctr_clr       = 1'b0;
      ctr_load1     = 1'b0;
      ctr_adv       = 1'b0;

      if (din_valid) begin
         case (state)
            HUNT: begin
               if (frame) begin
                  shadow_nxt = shadow_put(shadow, 2'd0, din);
                  ctr_load1  = 1'b1;
                  err_nxt    = '0;
                  state_nxt  = LOCKED;
               end
            end

            LOCKED: begin
               if (frame) begin
                  if (sel == 2'd0) begin
                     shadow_nxt = shadow_put(shadow, 2'd0, din);
                     ctr_load1  = 1'b1;
                  end else begin
                     // Early frame: drop the partial word, realign unless the limit is reached.
                     sync_err_nxt = 1'b1;
                     err_nxt      = err_sat;
                     if (!limit_hit) begin
                        shadow_nxt = shadow_put(shadow, 2'd0, din);
                        ctr_load1  = 1'b1;
                     end else begin
                        ctr_clr   = 1'b1;
                        state_nxt = HUNT;
                     end
                  end
               end else begin
                  if (sel == 2'd0) begin
                     sync_err_nxt = 1'b1;
                     err_nxt      = err_sat;
                     if (limit_hit) begin
                        state_nxt = HUNT;
                     end
                  end else if (sel == 2'd3) begin
                     out_nxt       = {din, shadow};
                     out_valid_nxt = 1'b1;
                     err_nxt       = '0;
                     ctr_adv       = 1'b1;
                  end else begin
                     shadow_nxt = shadow_put(shadow, sel, din);
                     ctr_adv    = 1'b1;
                  end
               end
            end

            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         shadow    <= '0;
         err_cnt   <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         state     <= state_nxt;
         shadow    <= shadow_nxt;
         err_cnt   <= err_nxt;
         out       <= out_nxt;
         out_valid <= out_valid_nxt;
         sync_err  <= sync_err_nxt;
      end
   end

   // state is a single flop with LOCKED encoded as 1, so this is a direct register output.
   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: expected words and error pulses go into queues, a monitor pops them.
module tb_tdm_demux4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       frame = 1'b0;
   logic [1:0] sel;
   logic [3:0] out;
   logic       out_valid;
   logic       locked;
   logic       sync_err;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_out_q[$];
   int         exp_err_q[$];

   tdm_demux4 #(.ERR_LIMIT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .frame     (frame),
      .sel       (sel),
      .out       (out),
      .out_valid (out_valid),
      .locked    (locked),
      .sync_err  (sync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: samples half a cycle after the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && sync_err) begin
            check("valid_and_err_overlap", 32'(out_valid & sync_err), 32'd0);
         end
         if (out_valid) begin
            if (exp_out_q.size() == 0) begin
               check("unexpected_out_valid", 32'(out), 32'hdead);
            end else begin
               check("out_word", 32'(out), 32'(exp_out_q.pop_front()));
            end
         end
         if (sync_err) begin
            if (exp_err_q.size() == 0) begin
               check("unexpected_sync_err", 32'(sync_err), 32'd0);
            end else begin
               check("sync_err_pulse", 32'(sync_err), 32'(exp_err_q.pop_front()));
            end
         end
      end
   end

   task automatic beat(input logic f, input logic d);
      din_valid = 1'b1;
      frame     = f;
      din       = d;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      frame     = 1'b0;
      din       = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
      end
      #1;
      rst = 1'b0;
   endtask

   // Sends a full frame; d[k] goes in slot k.
   task automatic send_frame(input logic [3:0] d);
      exp_out_q.push_back(d);
      beat(1'b1, d[0]);
      beat(1'b0, d[1]);
      beat(1'b0, d[2]);
      beat(1'b0, d[3]);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, checks %0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] walk;

      // Reset and lock
      @(posedge clk);
      #1;
      do_reset(2);
      check("rst_out", 32'(out), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      check("rst_sync_err", 32'(sync_err), 32'h0);

      exp_out_q.push_back(4'b0101);
      beat(1'b1, 1'b1);
      check("lock_after_first", 32'(locked), 32'h1);
      check("sel_after_first", 32'(sel), 32'h1);
      beat(1'b0, 1'b0);
      beat(1'b0, 1'b1);
      beat(1'b0, 1'b0);
      check("sel_wrap", 32'(sel), 32'h0);
      idle(1);
      check("out_hold_0101", 32'(out), 32'h5);
      check("out_valid_single", 32'(out_valid), 32'h0);

      // Slot walk
      for (int k = 0; k < 4; k++) begin
         walk = 4'b0001 << k;
         send_frame(walk);
      end
      idle(1);
      check("walk_last", 32'(out), 32'h8);

      // Gaps: sel must hold between beats
      exp_out_q.push_back(4'b1111);
      for (int i = 0; i < 4; i++) begin
         beat(i == 0, 1'b1);
         for (int g = 0; g < 3; g++) begin
            check("gap_sel", 32'(sel), 32'((i + 1) % 4));
            idle(1);
         end
      end
      check("gap_out", 32'(out), 32'hf);

      // Early frame at sel=2, realign
      beat(1'b1, 1'b0);
      beat(1'b0, 1'b1);
      check("sel_before_early", 32'(sel), 32'h2);
      exp_err_q.push_back(1);
      beat(1'b1, 1'b1);
      check("early_locked", 32'(locked), 32'h1);
      check("early_sel_realign", 32'(sel), 32'h1);
      check("early_err_cnt", 32'(dut.err_cnt), 32'h1);
      check("early_out_unchanged", 32'(out), 32'hf);
      exp_out_q.push_back(4'b1101);
      beat(1'b0, 1'b0);
      beat(1'b0, 1'b1);
      beat(1'b0, 1'b1);
      check("realign_err_cleared", 32'(dut.err_cnt), 32'h0);
      idle(1);

      // Loss of lock via two missing frames
      exp_err_q.push_back(1);
      beat(1'b0, 1'b1);
      check("miss1_locked", 32'(locked), 32'h1);
      check("miss1_sel", 32'(sel), 32'h0);
      exp_err_q.push_back(1);
      beat(1'b0, 1'b1);
      check("miss2_unlocked", 32'(locked), 32'h0);
      for (int i = 0; i < 3; i++) begin
         beat(1'b0, 1'b1);
      end
      check("hunt_sel", 32'(sel), 32'h0);
      check("hunt_locked", 32'(locked), 32'h0);
      check("hunt_out_hold", 32'(out), 32'hd);

      // Reset mid-frame
      beat(1'b1, 1'b1);
      beat(1'b0, 1'b1);
      do_reset(1);
      check("midrst_out", 32'(out), 32'h0);
      check("midrst_sel", 32'(sel), 32'h0);
      check("midrst_locked", 32'(locked), 32'h0);
      check("midrst_out_valid", 32'(out_valid), 32'h0);
      send_frame(4'b0110);
      idle(2);
      check("post_rst_out", 32'(out), 32'h6);

      check("out_queue_drained", 32'(exp_out_q.size()), 32'h0);
      check("err_queue_drained", 32'(exp_err_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
